// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode types: opcodes, raw instruction layout, the fetch-to-decode
// payload, and immediate extraction helpers used by the static predictor.
package fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011
    } OpCode;

    // R-type field split; other formats are reassembled from these fields.
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instruction_undecoded_t;

    typedef struct packed {
        instruction_undecoded_t instruction;
        logic [XLEN-1:0]        program_counter;
        logic                   branch_taken_prediction;
    } fetch_to_decode_t;

    // B-type offset: {inst[31], inst[7], inst[30:25], inst[11:8], 0}, sign-extended.
    function automatic logic [XLEN-1:0] b_immediate(input instruction_undecoded_t i);
        return {{20{i.funct7[6]}}, i.rd[0], i.funct7[5:0], i.rd[4:1], 1'b0};
    endfunction

    // J-type offset: {inst[31], inst[19:12], inst[20], inst[30:21], 0}, sign-extended.
    function automatic logic [XLEN-1:0] j_immediate(input instruction_undecoded_t i);
        return {{12{i.funct7[6]}}, i.rs1, i.funct3, i.rs2[0], i.funct7[5:0], i.rs2[4:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_unit_buffer.sv
// fetch_buffer: synchronous FIFO of fetch_to_decode_t with push, pop and flush.
// Ports: clk, reset_n (async active-low), push/push_data, pop, flush,
//        head_data (current head, registered storage), occupancy (entry count).
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  fetch_to_decode_t push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_to_decode_t head_data,
    output logic [CNT_W-1:0] occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_to_decode_t mem_q [DEPTH];
    fetch_to_decode_t mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state: flush wins over push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign occupancy = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Issues word requests under a credit limit,
// tags in-order responses with their PC, predicts JAL / backward branches taken,
// and discards stale responses after a redirect.
// Ports: clk, reset_n; imem_req_* (request out), imem_rsp_* (response in);
//        redirect_valid/redirect_pc (execute flush); decode_valid/ready/data (to decode).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [31:0]      imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             decode_valid,
    input  logic             decode_ready,
    output fetch_to_decode_t decode_data
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_count_q, drop_count_d;

    instruction_undecoded_t rsp_word;
    fetch_to_decode_t       push_data;
    logic [CNT_W-1:0]       occupancy;
    logic [CNT_W-1:0]       outstanding_after_rsp;
    logic [31:0]            pred_target;
    logic [31:0]            redirect_target;
    logic                   rsp_live;
    logic                   pred_taken;
    logic                   redirect_event;
    logic                   credit_ok;
    logic                   req_fire;
    logic                   buf_pop;
    logic                   unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Response classification, static prediction and redirect selection.
    always_comb begin
        rsp_word    = instruction_undecoded_t'(imem_rsp_data);
        rsp_live    = imem_rsp_valid && (drop_count_q == '0) && !redirect_valid;
        pred_taken  = 1'b0;
        pred_target = resp_pc_q + b_immediate(rsp_word);
        if (rsp_word.opcode == OP_JAL) begin
            pred_taken  = rsp_live;
            pred_target = resp_pc_q + j_immediate(rsp_word);
        end else if (rsp_word.opcode == OP_BRANCH && imem_rsp_data[31]) begin
            pred_taken  = rsp_live;
        end
        redirect_event  = redirect_valid || pred_taken;
        redirect_target = redirect_valid ? {redirect_pc[31:2], 2'b00} : pred_target;

        // Credits cover both in-flight requests and buffered entries, so a
        // response always has a free slot.
        credit_ok = (SUM_W'(outstanding_q) + SUM_W'(occupancy)) < SUM_W'(BUF_DEPTH);
        // Gated by reset_n so the request is low the moment reset asserts.
        imem_req_valid = reset_n && credit_ok && !redirect_event;
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;

        push_data.instruction             = rsp_word;
        push_data.program_counter         = resp_pc_q;
        push_data.branch_taken_prediction = pred_taken;

        decode_valid = (occupancy != '0) && !redirect_valid;
        buf_pop      = decode_valid && decode_ready;
    end

    // Next-state for PCs and counters.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        drop_count_d  = drop_count_q;

        outstanding_after_rsp = outstanding_q - CNT_W'(imem_rsp_valid);
        outstanding_d         = outstanding_after_rsp + CNT_W'(req_fire);

        if (redirect_event) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc_d   = redirect_target;
            resp_pc_d    = redirect_target;
            drop_count_d = outstanding_after_rsp;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rsp_live) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (imem_rsp_valid && (drop_count_q != '0)) begin
                drop_count_d = drop_count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_count_q  <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_count_q  <= drop_count_d;
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (rsp_live),
        .push_data (push_data),
        .pop       (buf_pop),
        .flush     (redirect_valid),
        .head_data (decode_data),
        .occupancy (occupancy)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push expected decode
// entries into a queue; a monitor pops and compares on each decode handshake.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] BEQ_M4 = 32'hFE00_0EE3;
    localparam logic [31:0] JAL_P8 = 32'h0080_00EF;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [31:0]      imem_req_addr;
    logic             imem_rsp_valid;
    logic [31:0]      imem_rsp_data;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             decode_valid;
    logic             decode_ready;
    fetch_to_decode_t decode_data;

    fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .decode_valid   (decode_valid),
        .decode_ready   (decode_ready),
        .decode_data    (decode_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fires = 0;
    int npop = 0;
    int first_pop = 0;
    int last_pop = 0;
    int mem_lat = 1;
    bit mon_en = 1'b0;
    bit beq_armed = 1'b0;
    bit jal_armed = 1'b0;
    fetch_to_decode_t exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [31:0] pc, input logic p);
        fetch_to_decode_t e;
        e.instruction             = instruction_undecoded_t'(d);
        e.program_counter         = pc;
        e.branch_taken_prediction = p;
        exp_q.push_back(e);
    endtask

    task automatic push_nops(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) push_exp(NOP, start + 32'(4 * i), 1'b0);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d entries still expected after %0d cycles", name, exp_q.size(), budget);
            exp_q.delete();
        end
        mon_en = 1'b0;
    endtask

    task automatic do_reset(input int lat);
        reset_n = 1'b0;
        mem_lat = lat;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        npop           = 0;
        mon_en         = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = pc;
    endtask

    // In-order memory with 1- or 2-cycle latency; squashes in-flight data on reset.
    initial begin
        logic        f;
        logic        r;
        logic [31:0] w;
        logic        hv;
        logic [31:0] hd;
        hv = 1'b0;
        hd = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            r = reset_n;
            f = reset_n && imem_req_valid && imem_req_ready;
            w = NOP;
            if (f) begin
                fires++;
                if (beq_armed && imem_req_addr == 32'h200) begin
                    w = BEQ_M4;
                    beq_armed = 1'b0;
                end else if (jal_armed && imem_req_addr == 32'h300) begin
                    w = JAL_P8;
                end
            end
            @(posedge clk);
            #1;
            if (!r) begin
                hv = 1'b0;
                imem_rsp_valid = 1'b0;
            end else if (mem_lat == 1) begin
                imem_rsp_valid = f;
                imem_rsp_data  = w;
            end else begin
                imem_rsp_valid = hv;
                imem_rsp_data  = hd;
                hv = f;
                hd = w;
            end
        end
    end

    // Monitor: compare each delivered entry against the scoreboard head.
    always @(negedge clk) begin
        if (reset_n && mon_en && decode_valid && decode_ready) begin
            if (npop == 0) first_pop = cyc;
            last_pop = cyc;
            npop++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL decode_extra: got pc %h data %h pred %0b, expected nothing",
                         decode_data.program_counter, decode_data.instruction, decode_data.branch_taken_prediction);
            end else begin
                fetch_to_decode_t e;
                e = exp_q.pop_front();
                if (decode_data !== e) begin
                    errors++;
                    $display("FAIL decode_entry: got pc %h data %h pred %0b, expected pc %h data %h pred %0b",
                             decode_data.program_counter, decode_data.instruction, decode_data.branch_taken_prediction,
                             e.program_counter, e.instruction, e.branch_taken_prediction);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int f1;
        int f2;
        reset_n        = 1'b0;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        decode_ready   = 1'b1;

        // Reset state.
        @(negedge clk);
        chk("rst_req_valid", 65'(imem_req_valid), 65'(0));
        chk("rst_decode_valid", 65'(decode_valid), 65'(0));
        chk("rst_decode_data", 65'(decode_data), 65'(0));

        // Sequential NOP stream from RESET_PC, one per cycle.
        push_nops(RPC, 8);
        npop   = 0;
        mon_en = 1'b1;
        step();
        reset_n = 1'b1;
        @(negedge clk);
        chk("first_req_valid", 65'(imem_req_valid), 65'(1));
        chk("first_req_addr", 65'(imem_req_addr), 65'(RPC));
        wait_drain("seq", 100);
        chk("throughput_span", 65'(last_pop - first_pop), 65'(7));

        // Backward branch at 0x200, 2-cycle memory: 0x204 in flight is dropped.
        do_reset(2);
        beq_armed = 1'b1;
        step(); step(); step(); step();
        push_exp(NOP, 32'h1F8, 1'b0);
        push_exp(NOP, 32'h1FC, 1'b0);
        push_exp(BEQ_M4, 32'h200, 1'b1);
        push_exp(NOP, 32'h1FC, 1'b0);
        push_exp(NOP, 32'h200, 1'b0);
        push_exp(NOP, 32'h204, 1'b0);
        redirect_to(32'h1F8);
        step();
        redirect_valid = 1'b0;
        wait_drain("beq", 100);

        // JAL +8 at 0x300, 1-cycle memory.
        do_reset(1);
        jal_armed = 1'b1;
        step(); step(); step();
        push_exp(NOP, 32'h2F8, 1'b0);
        push_exp(NOP, 32'h2FC, 1'b0);
        push_exp(JAL_P8, 32'h300, 1'b1);
        push_exp(NOP, 32'h308, 1'b0);
        push_exp(NOP, 32'h30C, 1'b0);
        redirect_to(32'h2F8);
        step();
        redirect_valid = 1'b0;
        wait_drain("jal", 100);
        jal_armed = 1'b0;

        // External redirect with two in flight and a response this cycle.
        do_reset(2);
        step(); step(); step(); step(); step(); step();
        push_nops(32'h400, 3);
        redirect_to(32'h403);
        @(negedge clk);
        chk("redir_decode_valid", 65'(decode_valid), 65'(0));
        chk("redir_req_valid", 65'(imem_req_valid), 65'(0));
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("post_redir_req_valid", 65'(imem_req_valid), 65'(1));
        chk("post_redir_req_addr", 65'(imem_req_addr), 65'(32'h400));
        wait_drain("ext_redir", 100);

        // Decode stall: requests stop at the credit limit, nothing lost.
        do_reset(1);
        step(); step(); step();
        push_nops(32'h500, 12);
        redirect_to(32'h500);
        step();
        redirect_valid = 1'b0;
        f0 = fires;
        step(); step(); step();
        decode_ready = 1'b0;
        step(); step(); step(); step();
        f1 = fires;
        step(); step(); step(); step(); step(); step();
        f2 = fires;
        chk("stall_no_requests", 65'(f2 - f1), 65'(0));
        chk("stall_credit_fill", 65'((f2 - f0) - npop), 65'(DEPTH));
        decode_ready = 1'b1;
        wait_drain("stall", 100);

        // PC wrap at the top of the address space.
        do_reset(1);
        step(); step();
        push_nops(32'hFFFF_FFF8, 4);
        redirect_to(32'hFFFF_FFF8);
        step();
        redirect_valid = 1'b0;
        wait_drain("wrap", 100);

        // Reset mid-operation with a full buffer.
        do_reset(1);
        step(); step();
        decode_ready = 1'b0;
        step(); step(); step(); step(); step();
        reset_n = 1'b0;
        #1;
        chk("midrst_decode_valid", 65'(decode_valid), 65'(0));
        chk("midrst_req_valid", 65'(imem_req_valid), 65'(0));
        chk("midrst_decode_data", 65'(decode_data), 65'(0));
        push_nops(RPC, 3);
        npop   = 0;
        mon_en = 1'b1;
        decode_ready = 1'b1;
        step();
        step();
        reset_n = 1'b1;
        @(negedge clk);
        chk("restart_req_addr", 65'(imem_req_addr), 65'(RPC));
        wait_drain("restart", 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
